// File: rtl/sdrd_pkg.sv
// Shared types and defaults for the SDRD serial word capture block.
// Optional build macro: SDRD_PARITY_EN appends an odd-parity bit to every word.
package sdrd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cap_state_e;

  localparam int WORD_W_DEF      = 16;
  localparam int TIMEOUT_CYC_DEF = 255;

  // Number of serial bits that make up one framed word.
  function automatic int word_len(input int word_w);
`ifdef SDRD_PARITY_EN
    return word_w + 1;
`else
    return word_w;
`endif
  endfunction

endpackage

// File: rtl/sdrd_strobe_det.sv
// Rising-edge detector on the SDRD bus qualifier; one strobe per qualifier assertion.
module sdrd_strobe_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sser_n,
  input  logic ba13,
  input  logic ba12,
  input  logic br_w,
  output logic strobe
);

  logic qual;
  logic qual_d;
  logic armed;

  assign qual = ~sser_n & ~ba13 & ba12 & br_w;

  // armed masks the first cycle after reset, when qual_d is still 0 even if qual was already high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      qual_d <= 1'b0;
      armed  <= 1'b0;
    end else begin
      qual_d <= qual;
      armed  <= 1'b1;
    end
  end

  assign strobe = qual & ~qual_d & armed;

endmodule

// File: rtl/sdrd_word_capture.sv
// Assembles SDRD serial read bits (MSB first) into words with a valid/ready output.
// Optional build macro: SDRD_PARITY_EN (word length WORD_W+1, last bit odd parity).
module sdrd_word_capture
  import sdrd_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sser_n,
  input  logic              ba13,
  input  logic              ba12,
  input  logic              br_w,
  input  logic              sdrd,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overrun,
  output logic              parity_err,
  output logic [4:0]        bit_cnt
);

  localparam int LEN  = word_len(WORD_W);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  cap_state_e        state;
  logic [LEN-2:0]    shift_q;
  logic [TO_W-1:0]   idle_cnt;
  logic              strobe;
  logic [LEN-1:0]    shift_nxt;
  logic [WORD_W-1:0] data_nxt;
  logic              last_bit;
  logic              parity_ok;
  logic              load;
  logic              drop;

  sdrd_strobe_det u_strobe_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sser_n (sser_n),
    .ba13   (ba13),
    .ba12   (ba12),
    .br_w   (br_w),
    .strobe (strobe)
  );

  // Only LEN-1 bits are ever held; the final bit is used straight from sdrd.
  assign shift_nxt = {shift_q, sdrd};
  assign last_bit  = strobe && (bit_cnt == 5'(LEN - 1));

`ifdef SDRD_PARITY_EN
  assign data_nxt  = shift_nxt[LEN-1:1];
  assign parity_ok = ^shift_nxt;
`else
  assign data_nxt  = shift_nxt;
  assign parity_ok = 1'b1;
`endif

  assign load = last_bit & parity_ok & (~word_valid | word_ready);
  assign drop = last_bit & parity_ok & word_valid & ~word_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        word       <= data_nxt;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (strobe) begin
            shift_q  <= shift_nxt[LEN-2:0];
            bit_cnt  <= 5'd1;
            idle_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (strobe) begin
            shift_q  <= shift_nxt[LEN-2:0];
            idle_cnt <= '0;
            if (last_bit) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            // Silent abandon of a stalled partial word.
            shift_q  <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            state    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDRD_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= last_bit & ~parity_ok;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
